fm_sweep_sequencer: RTL
=======================

# fm_sweep_sequencer

Wishbone master that programs and sweeps the FM generator's register bank. On a start command it writes the modulation frequency and deviation registers, then steps the carrier centre-frequency register from a start value by a signed increment. It dwells a programmable number of cycles after every carrier write. It sits between a control source (host core or front-panel logic) and the FM generator's Wishbone slave port.

## Interface
- ACK_TIMEOUT, 255: cycles to wait for `i_wb_ack` after a strobe is accepted before aborting with error.
- DWELL_WIDTH, 24: width of the dwell counter and `i_dwell`.
- STEP_WIDTH, 16: width of the step count and index.
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start request, sampled in IDLE only.
- i_abort  in  1  abort request, level-sensitive.
- i_start_freq  in  32  first carrier increment word.
- i_step  in  32  signed carrier increment added per step.
- i_num_steps  in  STEP_WIDTH  number of steps; carrier writes = i_num_steps+1.
- i_dwell  in  DWELL_WIDTH  idle cycles after each carrier write.
- i_mod_freq  in  32  value for register 1 (modulation frequency).
- i_deviation  in  32  value for register 2 (modulation deviation).
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  2  register address: 0 carrier, 1 mod freq, 2 deviation.
- o_wb_data  out  32  write data.
- i_wb_ack, i_wb_stall  in  1 each  slave acknowledge and stall.
- o_busy  out  1  high from the cycle after start acceptance until return to IDLE.
- o_done  out  1  one-cycle pulse on normal completion.
- o_error  out  1  one-cycle pulse on ack timeout.
- o_step_index  out  STEP_WIDTH  index of the most recent carrier write.
- o_cur_freq  out  32  value of the most recent carrier write.

## Operation
- Every output is registered and resets to 0. State resets to IDLE.
- All inputs except `i_abort` are latched when `i_start` is accepted. Changes to them during a sweep are ignored.
- States: IDLE → WR_MODF → GAP → WR_DEV → GAP → WR_CAR → DWELL → (WR_CAR | DONE) → IDLE.
- Write cycle, common to every WR_* state:
  - cyc, stb and we are high, with addr and data valid.
  - stb drops on the first edge where `i_wb_stall`=0; cyc stays high.
  - On the edge where `i_wb_ack`=1, cyc drops and the FSM advances.
  - addr and data are held stable from strobe until ack.
- `i_wb_ack` is ignored when cyc is low.
- WR_CAR data:
  - First write: latched start freq.
  - Each later write: previous value + step, modulo 2^32 (wraps, no saturation; negative step allowed).
  - On ack, `o_cur_freq` and `o_step_index` update. Index goes 0..i_num_steps.
- DWELL:
  - Loads the latched dwell value and decrements once per cycle.
  - Exits when the counter is 0. Total DWELL length is i_dwell+1 cycles, so dwell 0 gives 1 cycle.
  - Exits to WR_CAR if index < num_steps, otherwise to DONE.
  - The final carrier write is also followed by its dwell.
- DONE: one cycle, `o_done`=1, then IDLE.
- Abort:
  - Abort seen while cyc is high: finish the current transaction (wait for ack or timeout), then go to IDLE. No `o_done`.
  - Abort seen in GAP or DWELL: go to IDLE next cycle.
  - Abort in IDLE is ignored. Abort has priority over a simultaneous `i_start`.
- Timeout:
  - A counter runs while cyc is high.
  - When it reaches ACK_TIMEOUT: cyc and stb drop, `o_error` pulses for one cycle, state goes to IDLE.
  - Registers 0–2 keep whatever was already written.
- Reset mid-sweep: all bus outputs drop immediately (asynchronous). No partial transaction is retried.

## Timing
- `i_start` high in IDLE at edge N → cyc, stb high from N+1 with addr 1.
- Zero-wait slave (stall 0, ack one cycle after strobe):
  - Each write has stb for 1 cycle and ack in the next cycle.
  - Each GAP lasts 1 cycle.
  - Config writes occupy N+1..N+6; the first carrier strobe is at N+7.
- Carrier write period with a zero-wait slave: 2 + (i_dwell+1) cycles.
- `o_busy` falls in the cycle after the DONE pulse. A new `i_start` is accepted in that same cycle.
- `o_cur_freq` updates in the cycle after the ack edge.

## Test plan
- Basic sweep, zero-wait slave:
  - Stimulus: start=1000, step=+250, steps=3, dwell=4, modf=596523, dev=250.
  - Required: writes addr1=596523, addr2=250, then addr0 = 1000, 1250, 1500, 1750.
  - Required: carrier strobes 7 cycles apart; `o_done` once; `o_step_index` ends at 3.
- Wrap and negative step:
  - start=0xFFFF_FF00, step=+0x200, steps=1 → second carrier write = 0x0000_0100.
  - start=100, step=−50 (0xFFFF_FFCE), steps=2 → 100, 50, 0.
- Stall/latency slave:
  - Stimulus: stall held 3 cycles, ack 2 cycles after accept.
  - Required: stb stays high exactly until stall drops; data and addr stable; cyc drops on the ack edge; no duplicate writes.
- Timeout:
  - Stimulus: slave never acks, ACK_TIMEOUT=255.
  - Required: cyc low after 255 cycles, `o_error` one-cycle pulse, `o_busy` low, no `o_done`.
- Abort:
  - Stimulus: abort asserted during the second DWELL.
  - Required: IDLE next cycle, no further writes, no `o_done`.
  - Stimulus: abort asserted during a stalled write.
  - Required: the write completes on ack, then IDLE.
- Reset mid-write:
  - Stimulus: drive `i_reset_n` low while stb is high.
  - Required: all outputs 0 asynchronously.
  - Required: after release, FSM is IDLE and a new start runs normally.

Source files
------------

// File: rtl/fm_sweep_sequencer.sv
// fm_sweep_sequencer
// Wishbone master for the FM generator register bank. A start command writes
// the modulation frequency (reg 1) and deviation (reg 2), then writes the
// carrier increment word (reg 0) num_steps+1 times, starting from a latched
// start value and adding a signed step each time, dwelling after every write.
//
// Bus handshake (single classic-pipelined write per transaction):
//   - A write presents cyc=stb=we=1 with addr/data on the same cycle.
//   - The strobe is accepted on the first rising edge where i_wb_stall=0;
//     stb drops there while cyc stays high.
//   - The transaction ends on the rising edge where i_wb_ack=1; cyc drops.
//   - addr/data are held from the first strobe cycle until after the ack.
//   - i_wb_ack is only looked at while cyc is high.
//   - If no ack arrives within ACK_TIMEOUT cycles of cyc high, the write
//     is abandoned, o_error pulses and the sequencer returns to idle.
//
// o_dbg_state exposes the FSM state: 0 IDLE, 1 WR_MODF, 2 GAP, 3 WR_DEV,
// 4 WR_CAR, 5 DWELL, 6 DONE.
module fm_sweep_sequencer #(
  parameter int ACK_TIMEOUT = 255,
  parameter int DWELL_WIDTH = 24,
  parameter int STEP_WIDTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [31:0]            i_start_freq,
  input  logic [31:0]            i_step,
  input  logic [STEP_WIDTH-1:0]  i_num_steps,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  input  logic [31:0]            i_mod_freq,
  input  logic [31:0]            i_deviation,
  output logic                   o_wb_cyc,
  output logic                   o_wb_stb,
  output logic                   o_wb_we,
  output logic [1:0]             o_wb_addr,
  output logic [31:0]            o_wb_data,
  input  logic                   i_wb_ack,
  input  logic                   i_wb_stall,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [STEP_WIDTH-1:0]  o_step_index,
  output logic [31:0]            o_cur_freq,
  output logic [2:0]             o_dbg_state
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  // Last count value before the timeout fires; cyc is high for exactly
  // ACK_TIMEOUT cycles when no ack arrives.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] ADDR_CAR  = 2'd0;
  localparam logic [1:0] ADDR_MODF = 2'd1;
  localparam logic [1:0] ADDR_DEV  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_MODF = 3'd1,
    S_GAP     = 3'd2,
    S_WR_DEV  = 3'd3,
    S_WR_CAR  = 3'd4,
    S_DWELL   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                 state_q, state_d;

  // Sweep parameters captured at start; the modulation frequency needs no
  // separate copy because it goes straight into the first write's data.
  logic [31:0]            start_freq_q, start_freq_d;
  logic [31:0]            step_q, step_d;
  logic [STEP_WIDTH-1:0]  num_steps_q, num_steps_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [31:0]            deviation_q, deviation_d;

  // Bus outputs
  logic                   wb_cyc_q, wb_cyc_d;
  logic                   wb_stb_q, wb_stb_d;
  logic                   wb_we_q, wb_we_d;
  logic [1:0]             wb_addr_q, wb_addr_d;
  logic [31:0]            wb_data_q, wb_data_d;

  // Status outputs
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [STEP_WIDTH-1:0]  step_index_q, step_index_d;
  logic [31:0]            cur_freq_q, cur_freq_d;

  // Working counters and flags
  logic [STEP_WIDTH-1:0]  idx_q, idx_d;          // index of carrier write in flight
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   abort_pend_q, abort_pend_d;

  // Next-state and next-output computation for the whole sequencer
  always_comb begin
    state_d      = state_q;
    start_freq_d = start_freq_q;
    step_d       = step_q;
    num_steps_d  = num_steps_q;
    dwell_d      = dwell_q;
    deviation_d  = deviation_q;
    wb_cyc_d     = wb_cyc_q;
    wb_stb_d     = wb_stb_q;
    wb_we_d      = wb_we_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    step_index_d = step_index_q;
    cur_freq_d   = cur_freq_q;
    idx_d        = idx_q;
    dwell_cnt_d  = dwell_cnt_q;
    to_cnt_d     = to_cnt_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      S_IDLE: begin
        // Abort wins over a simultaneous start.
        if (i_start && !i_abort) begin
          start_freq_d = i_start_freq;
          step_d       = i_step;
          num_steps_d  = i_num_steps;
          dwell_d      = i_dwell;
          deviation_d  = i_deviation;
          abort_pend_d = 1'b0;
          state_d      = S_WR_MODF;
          wb_cyc_d     = 1'b1;
          wb_stb_d     = 1'b1;
          wb_we_d      = 1'b1;
          wb_addr_d    = ADDR_MODF;
          wb_data_d    = i_mod_freq;
          to_cnt_d     = '0;
        end
      end

      S_WR_MODF, S_WR_DEV, S_WR_CAR: begin
        // An abort during a write is remembered; the write still finishes.
        if (i_abort) begin
          abort_pend_d = 1'b1;
        end
        if (wb_stb_q && !i_wb_stall) begin
          wb_stb_d = 1'b0;
        end
        if (i_wb_ack) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
          if (state_q == S_WR_CAR) begin
            cur_freq_d   = wb_data_q;
            step_index_d = idx_q;
          end
          if (i_abort || abort_pend_q) begin
            state_d = S_IDLE;
          end else if (state_q == S_WR_CAR) begin
            state_d     = S_DWELL;
            dwell_cnt_d = dwell_q;
          end else begin
            state_d = S_GAP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Give up on the slave; registers already written stay written.
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          wb_we_d  = 1'b0;
          error_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_GAP: begin
        // The address of the write just finished tells which one comes next.
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          wb_cyc_d = 1'b1;
          wb_stb_d = 1'b1;
          wb_we_d  = 1'b1;
          to_cnt_d = '0;
          if (wb_addr_q == ADDR_MODF) begin
            state_d   = S_WR_DEV;
            wb_addr_d = ADDR_DEV;
            wb_data_d = deviation_q;
          end else begin
            state_d   = S_WR_CAR;
            wb_addr_d = ADDR_CAR;
            wb_data_d = start_freq_q;
            idx_d     = '0;
          end
        end
      end

      S_DWELL: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (dwell_cnt_q == '0) begin
          if (idx_q < num_steps_q) begin
            // Next carrier value wraps modulo 2^32; step may be negative.
            state_d   = S_WR_CAR;
            wb_cyc_d  = 1'b1;
            wb_stb_d  = 1'b1;
            wb_we_d   = 1'b1;
            wb_addr_d = ADDR_CAR;
            wb_data_d = cur_freq_q + step_q;
            idx_d     = idx_q + STEP_WIDTH'(1);
            to_cnt_d  = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; asynchronous reset clears everything
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      start_freq_q <= '0;
      step_q       <= '0;
      num_steps_q  <= '0;
      dwell_q      <= '0;
      deviation_q  <= '0;
      wb_cyc_q     <= 1'b0;
      wb_stb_q     <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      step_index_q <= '0;
      cur_freq_q   <= '0;
      idx_q        <= '0;
      dwell_cnt_q  <= '0;
      to_cnt_q     <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_freq_q <= start_freq_d;
      step_q       <= step_d;
      num_steps_q  <= num_steps_d;
      dwell_q      <= dwell_d;
      deviation_q  <= deviation_d;
      wb_cyc_q     <= wb_cyc_d;
      wb_stb_q     <= wb_stb_d;
      wb_we_q      <= wb_we_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      step_index_q <= step_index_d;
      cur_freq_q   <= cur_freq_d;
      idx_q        <= idx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      to_cnt_q     <= to_cnt_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign o_wb_cyc     = wb_cyc_q;
  assign o_wb_stb     = wb_stb_q;
  assign o_wb_we      = wb_we_q;
  assign o_wb_addr    = wb_addr_q;
  assign o_wb_data    = wb_data_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_step_index = step_index_q;
  assign o_cur_freq   = cur_freq_q;
  assign o_dbg_state  = state_q;

endmodule
